chacha_qr_engine: RTL and testbench



---
 rtl/chacha_pkg.sv | 31 +++
 rtl/chacha_arx_step.sv | 44 ++++
 rtl/chacha_qr_engine.sv | 153 +++++++++++++++
 tb/tb_chacha_qr_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha quarter-round engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chacha_pkg;

    localparam int WORD_W      = 32;
    localparam int ROT0        = 16;
    localparam int ROT1        = 12;
    localparam int ROT2        = 8;
    localparam int ROT3        = 7;
    localparam int MAX_QR_ITER = 255;
    // Wide enough to count every step of the longest operation without wrapping.
    localparam int STEP_CNT_W  = $clog2(4 * MAX_QR_ITER);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
    } qr_state_t;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/chacha_arx_step.sv
// One ChaCha ARX step (add, xor, rotate) selected by a 2-bit step index.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module chacha_arx_step
    import chacha_pkg::*;
(
    input  logic [1:0]        step_idx,
    input  logic [WORD_W-1:0] a_in,
    input  logic [WORD_W-1:0] b_in,
    input  logic [WORD_W-1:0] c_in,
    input  logic [WORD_W-1:0] d_in,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] b_out,
    output logic [WORD_W-1:0] c_out,
    output logic [WORD_W-1:0] d_out
);

    // Even steps update a then d, odd steps update c then b.
    always_comb begin
        a_out = a_in;
        b_out = b_in;
        c_out = c_in;
        d_out = d_in;
        unique case (step_idx)
            2'd0: begin
                a_out = a_in + b_in;
                d_out = rotl(d_in ^ (a_in + b_in), ROT0);
            end
            2'd1: begin
                c_out = c_in + d_in;
                b_out = rotl(b_in ^ (c_in + d_in), ROT1);
            end
            2'd2: begin
                a_out = a_in + b_in;
                d_out = rotl(d_in ^ (a_in + b_in), ROT2);
            end
            2'd3: begin
                c_out = c_in + d_in;
                b_out = rotl(b_in ^ (c_in + d_in), ROT3);
            end
        endcase
    end

endmodule

// File: rtl/chacha_qr_engine.sv
// Four-word ChaCha state register file with an in-place quarter-round engine.
// Latency: 4*QR_ITER/STEPS_PER_CYCLE busy cycles from start to the done pulse.
// Backpressure: writes and start are ignored while busy; reads are always live.
module chacha_qr_engine
    import chacha_pkg::*;
#(
    parameter  int BUS_W           = 8,
    parameter  int QR_ITER         = 1,
    parameter  int STEPS_PER_CYCLE = 1,
    localparam int ADDR_W          = 2 + $clog2(32 / BUS_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wr_data,
    output logic [BUS_W-1:0]  rd_data,
    input  logic              start,
    output logic              busy,
    output logic              done
);

    localparam int LANE_W      = ADDR_W - 2;
    localparam int LSEL_W      = (LANE_W > 0) ? LANE_W : 1;
    localparam int TOTAL_STEPS = 4 * QR_ITER;
    localparam int SPC         = STEPS_PER_CYCLE;

    if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32)) begin : g_bad_bus_w
        $error("chacha_qr_engine: BUS_W must be 8, 16 or 32");
    end
    if (!(SPC == 1 || SPC == 2 || SPC == 4)) begin : g_bad_spc
        $error("chacha_qr_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
    end
    if (QR_ITER < 1 || QR_ITER > MAX_QR_ITER) begin : g_bad_iter
        $error("chacha_qr_engine: QR_ITER must be in 1..255");
    end

    qr_state_t             st_q, st_d;
    state_e                state_q, state_d;
    logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [1:0]            word_sel;
    logic [LSEL_W-1:0]     lane_sel;
    logic [4:0]            lane_lsb;
    logic [WORD_W-1:0]     sel_word;
    logic [WORD_W-1:0]     wr_word;

    assign word_sel = addr[ADDR_W-1 -: 2];
    if (LANE_W > 0) begin : g_lanes
        assign lane_sel = addr[LSEL_W-1:0];
    end else begin : g_no_lanes
        assign lane_sel = '0;
    end
    assign lane_lsb = 5'(int'(lane_sel) * BUS_W);

    // Addressed word and lane of the live register contents.
    always_comb begin
        sel_word = st_q.a;
        unique case (word_sel)
            2'd0: sel_word = st_q.a;
            2'd1: sel_word = st_q.b;
            2'd2: sel_word = st_q.c;
            2'd3: sel_word = st_q.d;
        endcase
        rd_data = sel_word[lane_lsb +: BUS_W];
    end

    // Chain of ARX steps; step index continues from the committed step count.
    logic [WORD_W-1:0] a_ch [SPC+1];
    logic [WORD_W-1:0] b_ch [SPC+1];
    logic [WORD_W-1:0] c_ch [SPC+1];
    logic [WORD_W-1:0] d_ch [SPC+1];

    assign a_ch[0] = st_q.a;
    assign b_ch[0] = st_q.b;
    assign c_ch[0] = st_q.c;
    assign d_ch[0] = st_q.d;

    for (genvar k = 0; k < SPC; k++) begin : g_chain
        chacha_arx_step u_step (
            .step_idx (cnt_q[1:0] + 2'(k)),
            .a_in     (a_ch[k]),
            .b_in     (b_ch[k]),
            .c_in     (c_ch[k]),
            .d_in     (d_ch[k]),
            .a_out    (a_ch[k+1]),
            .b_out    (b_ch[k+1]),
            .c_out    (c_ch[k+1]),
            .d_out    (d_ch[k+1])
        );
    end

    // Next state: lane writes and start in IDLE, step commits and completion in BUSY.
    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_word = sel_word;
        wr_word[lane_lsb +: BUS_W] = wr_data;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    unique case (word_sel)
                        2'd0: st_d.a = wr_word;
                        2'd1: st_d.b = wr_word;
                        2'd2: st_d.c = wr_word;
                        2'd3: st_d.d = wr_word;
                    endcase
                end
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                st_d.a = a_ch[SPC];
                st_d.b = b_ch[SPC];
                st_d.c = c_ch[SPC];
                st_d.d = d_ch[SPC];
                cnt_d  = cnt_q + STEP_CNT_W'(SPC);
                if (cnt_d == STEP_CNT_W'(TOTAL_STEPS)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // State registers; reset abandons any running computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_chacha_qr_engine.sv
// Bench for chacha_qr_engine across three bus-width / throughput configurations.
// Latency: checks busy length and the one-cycle done pulse per configuration.
// Backpressure: exercises writes and restarts while busy, and reset mid-operation.
module tb_chacha_qr_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // u=0: BUS_W=8, QR_ITER=1, SPC=1
    logic       wr_en0, start0, busy0, done0;
    logic [3:0] addr0;
    logic [7:0] wd0, rd0;
    // u=1: BUS_W=32, QR_ITER=2, SPC=2
    logic        wr_en1, start1, busy1, done1;
    logic [1:0]  addr1;
    logic [31:0] wd1, rd1;
    // u=2: BUS_W=32, QR_ITER=1, SPC=4
    logic        wr_en2, start2, busy2, done2;
    logic [1:0]  addr2;
    logic [31:0] wd2, rd2;

    chacha_qr_engine #(.BUS_W(8), .QR_ITER(1), .STEPS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .addr(addr0), .wr_data(wd0),
        .rd_data(rd0), .start(start0), .busy(busy0), .done(done0));
    chacha_qr_engine #(.BUS_W(32), .QR_ITER(2), .STEPS_PER_CYCLE(2)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .addr(addr1), .wr_data(wd1),
        .rd_data(rd1), .start(start1), .busy(busy1), .done(done1));
    chacha_qr_engine #(.BUS_W(32), .QR_ITER(1), .STEPS_PER_CYCLE(4)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .addr(addr2), .wr_data(wd2),
        .rd_data(rd2), .start(start2), .busy(busy2), .done(done2));

    int checks = 0;
    int errors = 0;

    typedef logic [3:0][31:0] st4_t; // [0]=a, [1]=b, [2]=c, [3]=d

    localparam st4_t RFC_IN  = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};
    localparam st4_t RFC_OUT = {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4};

    function automatic logic [31:0] rol(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Full ChaCha quarter-round, applied iters times.
    function automatic st4_t ref_qr(st4_t s, int iters);
        logic [31:0] a, b, c, d;
        a = s[0]; b = s[1]; c = s[2]; d = s[3];
        for (int i = 0; i < iters; i++) begin
            a = a + b; d = rol(d ^ a, 16);
            c = c + d; b = rol(b ^ c, 12);
            a = a + b; d = rol(d ^ a, 8);
            c = c + d; b = rol(b ^ c, 7);
        end
        return {d, c, b, a};
    endfunction

    function automatic int iters_of(int u);
        return (u == 1) ? 2 : 1;
    endfunction

    function automatic int busy_len(int u);
        return (u == 0) ? 4 : (u == 1) ? 4 : 1;
    endfunction

    function automatic logic get_busy(int u);
        return (u == 0) ? busy0 : (u == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_done(int u);
        return (u == 0) ? done0 : (u == 1) ? done1 : done2;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_start(int u, logic v);
        case (u)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic wr(int u, logic [3:0] ad, logic [31:0] v);
        case (u)
            0: begin addr0 = ad; wd0 = v[7:0]; wr_en0 = 1'b1; end
            1: begin addr1 = ad[1:0]; wd1 = v; wr_en1 = 1'b1; end
            default: begin addr2 = ad[1:0]; wd2 = v; wr_en2 = 1'b1; end
        endcase
        @(posedge clk); #1;
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    task automatic load(int u, st4_t s);
        for (int w = 0; w < 4; w++) begin
            if (u == 0) begin
                for (int l = 0; l < 4; l++) wr(0, 4'(w * 4 + l), s[w] >> (8 * l));
            end else begin
                wr(u, 4'(w), s[w]);
            end
        end
    endtask

    task automatic rd_word(int u, int w, output logic [31:0] v);
        v = '0;
        if (u == 0) begin
            for (int l = 0; l < 4; l++) begin
                @(negedge clk); addr0 = 4'(w * 4 + l); #1;
                v[8 * l +: 8] = rd0;
            end
        end else begin
            @(negedge clk);
            if (u == 1) addr1 = 2'(w); else addr2 = 2'(w);
            #1;
            v = (u == 1) ? rd1 : rd2;
        end
    endtask

    task automatic check_state(int u, string tag, st4_t exp);
        logic [31:0] v;
        for (int w = 0; w < 4; w++) begin
            rd_word(u, w, v);
            check($sformatf("%s u%0d word%0d", tag, u, w), v, exp[w]);
        end
    endtask

    // Start, optionally disturb during BUSY, then measure busy length and done pulse.
    task automatic run(int u, bit wr_busy, bit extra_start, string tag);
        int nb;
        logic d1, d2;
        set_start(u, 1'b1);
        @(posedge clk); #1;
        wr_en0 = 1'b0;
        set_start(u, extra_start);
        if (wr_busy) begin addr0 = 4'h0; wd0 = 8'hFF; wr_en0 = 1'b1; end
        nb = 0;
        while (get_busy(u) && nb < 100) begin
            nb++;
            @(posedge clk); #1;
            set_start(u, 1'b0);
            wr_en0 = 1'b0;
        end
        d1 = get_done(u);
        @(posedge clk); #1;
        d2 = get_done(u);
        check($sformatf("%s u%0d busy_cycles", tag, u), 32'(nb), 32'(busy_len(u)));
        check($sformatf("%s u%0d done_pulse", tag, u), 32'(d1), 32'd1);
        check($sformatf("%s u%0d done_clear", tag, u), 32'(d2), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        st4_t s, e;
        rst = 1'b1;
        wr_en0 = 0; start0 = 0; addr0 = 0; wd0 = 0;
        wr_en1 = 0; start1 = 0; addr1 = 0; wd1 = 0;
        wr_en2 = 0; start2 = 0; addr2 = 0; wd2 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset u%0d busy", u), 32'(get_busy(u)), 32'd0);
            check($sformatf("reset u%0d done", u), 32'(get_done(u)), 32'd0);
            check_state(u, "reset", '0);
        end

        // RFC 7539 quarter-round vector on every configuration
        for (int u = 0; u < 3; u++) begin
            load(u, RFC_IN);
            run(u, 1'b0, 1'b0, "rfc");
            e = (u == 1) ? ref_qr(RFC_IN, 2) : RFC_OUT;
            check_state(u, "rfc", e);
        end

        // Random vectors against the reference model
        for (int u = 0; u < 3; u++) begin
            for (int r = 0; r < 3; r++) begin
                for (int w = 0; w < 4; w++) s[w] = $urandom();
                load(u, s);
                run(u, 1'b0, 1'b0, "rand");
                check_state(u, "rand", ref_qr(s, iters_of(u)));
            end
        end

        // Lane isolation on the byte-wide port
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        wr(0, 4'h7, 32'hAB);
        check_state(0, "lane", {32'h0, 32'h0, 32'hAB000000, 32'h0});

        // Writes during BUSY are dropped
        load(0, RFC_IN);
        run(0, 1'b1, 1'b0, "wrbusy");
        check_state(0, "wrbusy", RFC_OUT);

        // Write coincident with start is used; restart while busy is ignored
        load(0, RFC_IN);
        addr0 = 4'h0; wd0 = 8'h12; wr_en0 = 1'b1;
        run(0, 1'b0, 1'b1, "wrstart");
        s = RFC_IN;
        s[0][7:0] = 8'h12;
        check_state(0, "wrstart", ref_qr(s, 1));

        // Reset on the second BUSY cycle
        for (int w = 0; w < 4; w++) s[w] = $urandom();
        load(0, s);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy0), 32'd0);
        check("midrst done", 32'(done0), 32'd0);
        check_state(0, "midrst", '0);
        for (int w = 0; w < 4; w++) s[w] = $urandom();
        load(0, s);
        run(0, 1'b0, 1'b0, "postrst");
        check_state(0, "postrst", ref_qr(s, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
